// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the multicycle RISC-V core:
// FSM state codes, opcodes and datapath mux/ALU/immediate select codes.
package riscv_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWRITE = 4'd4;
    localparam state_t S_MEMWB    = 4'd5;
    localparam state_t S_EXECR    = 4'd6;
    localparam state_t S_EXECI    = 4'd7;
    localparam state_t S_ALUWB    = 4'd8;
    localparam state_t S_BEQ      = 4'd9;
    localparam state_t S_JAL      = 4'd10;
    localparam state_t S_EXECLUI  = 4'd11;
    localparam state_t S_ILLEGAL  = 4'd12;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: opcode/flags/mem_ready in,
// enables and mux selects out. master = controller, slave = datapath.
interface multicycle_controller_if;

    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [2:0] imm_src;
    logic       illegal_op;
    logic       instr_done;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, adr_src, ir_write, mem_write, reg_write,
        output result_src, alu_src_a, alu_src_b, alu_op, imm_src,
        output illegal_op, instr_done
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, adr_src, ir_write, mem_write, reg_write,
        input  result_src, alu_src_a, alu_src_b, alu_op, imm_src,
        input  illegal_op, instr_done
    );

endinterface

// File: rtl/mc_imm_decoder.sv
// Combinational opcode -> immediate-format select, independent of FSM state.
// Ports: opcode_i (IR[6:0]) in, imm_src_o (I/S/B/J/U code) out.
module mc_imm_decoder
    import riscv_ctrl_pkg::*;
#(
    parameter bit EN_LUI = 1'b1
) (
    input  logic [6:0] opcode_i,
    output logic [2:0] imm_src_o
);

    always_comb begin
        imm_src_o = IMM_I;
        case (opcode_i)
            OP_SW:   imm_src_o = IMM_S;
            OP_BEQ:  imm_src_o = IMM_B;
            OP_JAL:  imm_src_o = IMM_J;
            OP_LUI:  imm_src_o = EN_LUI ? IMM_U : IMM_I;
            default: imm_src_o = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM with memory wait-states and illegal trap.
// Ports: clk, rst (async, active-high), bus (controller modport).
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter bit EN_LUI      = 1'b1,
    parameter bit TRAP_HALT   = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    multicycle_controller_if.master        bus
);

    state_t state_q, state_d;
    logic   rdy;
    logic   pc_update, branch;
    logic   ir_wr, mem_wr, reg_wr, done, ill;

    assign rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    mc_imm_decoder #(.EN_LUI(EN_LUI)) u_imm (
        .opcode_i  (bus.opcode),
        .imm_src_o (bus.imm_src)
    );

    always_comb begin
        state_d        = state_q;
        pc_update      = 1'b0;
        branch         = 1'b0;
        ir_wr          = 1'b0;
        mem_wr         = 1'b0;
        reg_wr         = 1'b0;
        done           = 1'b0;
        ill            = 1'b0;
        bus.adr_src    = 1'b0;
        bus.result_src = RES_ALUOUT;
        bus.alu_src_a  = SRCA_PC;
        bus.alu_src_b  = SRCB_RS2;
        bus.alu_op     = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                bus.alu_src_b  = SRCB_FOUR;
                bus.result_src = RES_ALURES;
                ir_wr          = rdy;
                pc_update      = rdy;
                if (rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_IMM;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_LUI:       state_d = EN_LUI ? S_EXECLUI : S_ILLEGAL;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
                state_d = (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                bus.adr_src = 1'b1;
                if (rdy) state_d = S_MEMWB;
            end
            S_MEMWRITE: begin
                bus.adr_src = 1'b1;
                mem_wr      = 1'b1;
                done        = rdy;
                if (rdy) state_d = S_FETCH;
            end
            S_MEMWB: begin
                bus.result_src = RES_DATA;
                reg_wr         = 1'b1;
                done           = 1'b1;
                state_d        = S_FETCH;
            end
            S_EXECR: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_op    = ALU_FUNCT;
                state_d       = S_ALUWB;
            end
            S_EXECI: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
                bus.alu_op    = ALU_FUNCT;
                state_d       = S_ALUWB;
            end
            S_EXECLUI: begin
                bus.alu_src_a = SRCA_ZERO;
                bus.alu_src_b = SRCB_IMM;
                state_d       = S_ALUWB;
            end
            S_ALUWB: begin
                reg_wr  = 1'b1;
                done    = 1'b1;
                state_d = S_FETCH;
            end
            S_BEQ: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_op    = ALU_SUB;
                branch        = 1'b1;
                done          = 1'b1;
                state_d       = S_FETCH;
            end
            S_JAL: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_FOUR;
                pc_update     = 1'b1;
                state_d       = S_ALUWB;
            end
            S_ILLEGAL: begin
                ill = 1'b1;
                if (!TRAP_HALT) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State is already FETCH during reset; only the strobes need masking,
    // since FETCH strobes follow mem_ready combinationally.
    assign bus.pc_write   = !rst && (pc_update || (branch && bus.zero));
    assign bus.ir_write   = !rst && ir_wr;
    assign bus.mem_write  = !rst && mem_wr;
    assign bus.reg_write  = !rst && reg_wr;
    assign bus.instr_done = !rst && done;
    assign bus.illegal_op = !rst && ill;

endmodule
